// File: rtl/multi_hit_resolver_pkg.sv
// Shared definitions for the multi-hit resolver: bullet colour codes,
// scan FSM states and colour classification helpers.
package multi_hit_resolver_pkg;

   localparam logic [2:0] COL_NONE   = 3'd0;
   localparam logic [2:0] COL_WHITE  = 3'd1;
   localparam logic [2:0] COL_BLUE   = 3'd2;
   localparam logic [2:0] COL_ORANGE = 3'd3;
   localparam logic [2:0] COL_GREEN  = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_APPLY = 2'd2
   } state_e;

   // Blue only hurts a moving player, orange only a stationary one.
   function automatic logic is_damaging(input logic [2:0] col, input logic moving);
      return (col == COL_WHITE) ||
             ((col == COL_BLUE) && moving) ||
             ((col == COL_ORANGE) && !moving);
   endfunction

   // Codes 5..7 decode as "none", so only the exact green code heals.
   function automatic logic is_healing(input logic [2:0] col);
      return col == COL_GREEN;
   endfunction

endpackage

// File: rtl/multi_hit_resolver_aabb.sv
// Combinational axis-aligned box overlap test. End coordinates are formed
// one bit wider than the inputs so boxes near the top of the coordinate
// range never wrap. Touching edges and zero-sized boxes do not count.
module aabb_hit #(
   parameter int COORD_W = 8
) (
   input  logic [COORD_W-1:0] ax_i,
   input  logic [COORD_W-1:0] ay_i,
   input  logic [COORD_W-1:0] aw_i,
   input  logic [COORD_W-1:0] ah_i,
   input  logic [COORD_W-1:0] bx_i,
   input  logic [COORD_W-1:0] by_i,
   input  logic [COORD_W-1:0] bw_i,
   input  logic [COORD_W-1:0] bh_i,
   output logic               hit_o
);

   logic [COORD_W:0] a_x_end, a_y_end, b_x_end, b_y_end;
   logic             nonzero, x_ovl, y_ovl;

   assign a_x_end = {1'b0, ax_i} + {1'b0, aw_i};
   assign a_y_end = {1'b0, ay_i} + {1'b0, ah_i};
   assign b_x_end = {1'b0, bx_i} + {1'b0, bw_i};
   assign b_y_end = {1'b0, by_i} + {1'b0, bh_i};

   assign nonzero = (aw_i != '0) && (ah_i != '0) && (bw_i != '0) && (bh_i != '0);
   assign x_ovl   = ({1'b0, ax_i} < b_x_end) && ({1'b0, bx_i} < a_x_end);
   assign y_ovl   = ({1'b0, ay_i} < b_y_end) && ({1'b0, by_i} < a_y_end);
   assign hit_o   = nonzero && x_ovl && y_ovl;

endmodule

// File: rtl/multi_hit_resolver.sv
// Per-frame bullet/player collision and HP resolver. A frame_tick snapshots
// all inputs, one channel per cycle is tested against the player box through
// a single shared overlap unit, then damage/heal is applied to HP in one step.
module multi_hit_resolver
   import multi_hit_resolver_pkg::*;
#(
   parameter int N_BULLETS    = 8,
   parameter int COORD_W      = 8,
   parameter int HP_W         = 8,
   parameter int HP_MAX       = 20,
   parameter int DMG_HIT      = 4,
   parameter int HEAL_AMT     = 2,
   parameter int IFRAME_TICKS = 10,
   localparam int IDX_W       = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             frame_tick,
   input  logic [2*COORD_W-1:0]             player_pos,
   input  logic [COORD_W-1:0]               player_size,
   input  logic                             player_moving,
   input  logic [N_BULLETS*2*COORD_W-1:0]   bullet_pos,
   input  logic [N_BULLETS*2*COORD_W-1:0]   bullet_size,
   input  logic [N_BULLETS*3-1:0]           bullet_color,
   input  logic [N_BULLETS-1:0]             bullet_valid,
   output logic [HP_W-1:0]                  hp_out,
   output logic                             hit_pulse,
   output logic                             heal_pulse,
   output logic [IDX_W-1:0]                 hit_index,
   output logic                             dead,
   output logic                             busy,
   output logic                             overrun
);

   localparam int IFR_W = (IFRAME_TICKS > 0) ? $clog2(IFRAME_TICKS + 1) : 1;
   localparam int SW    = HP_W + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BULLETS - 1);

   state_e                           state_q;
   logic [IDX_W-1:0]                 idx_q;
   logic [IFR_W-1:0]                 iframe_q;
   logic                             immune_q;
   logic [HP_W-1:0]                  hp_q, dmg_acc_q, heal_acc_q;
   logic                             found_q;
   logic [IDX_W-1:0]                 cand_q, hit_index_q;
   logic                             hit_pulse_q, heal_pulse_q, dead_q, overrun_q;

   // Frame snapshot
   logic [2*COORD_W-1:0]             ppos_q;
   logic [COORD_W-1:0]               psize_q;
   logic                             moving_q;
   logic [N_BULLETS*2*COORD_W-1:0]   bpos_q, bsize_q;
   logic [N_BULLETS*3-1:0]           bcol_q;
   logic [N_BULLETS-1:0]             bvalid_q;

   logic [COORD_W-1:0] snap_bx [N_BULLETS];
   logic [COORD_W-1:0] snap_by [N_BULLETS];
   logic [COORD_W-1:0] snap_bw [N_BULLETS];
   logic [COORD_W-1:0] snap_bh [N_BULLETS];
   logic [2:0]         snap_bc [N_BULLETS];

   for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_unpack
      assign snap_bx[gi] = bpos_q [gi*2*COORD_W + COORD_W +: COORD_W];
      assign snap_by[gi] = bpos_q [gi*2*COORD_W +: COORD_W];
      assign snap_bw[gi] = bsize_q[gi*2*COORD_W + COORD_W +: COORD_W];
      assign snap_bh[gi] = bsize_q[gi*2*COORD_W +: COORD_W];
      assign snap_bc[gi] = bcol_q [gi*3 +: 3];
   end

   logic overlap;

   aabb_hit #(.COORD_W(COORD_W)) u_aabb (
      .ax_i (ppos_q[2*COORD_W-1:COORD_W]),
      .ay_i (ppos_q[COORD_W-1:0]),
      .aw_i (psize_q),
      .ah_i (psize_q),
      .bx_i (snap_bx[idx_q]),
      .by_i (snap_by[idx_q]),
      .bw_i (snap_bw[idx_q]),
      .bh_i (snap_bh[idx_q]),
      .hit_o(overlap)
   );

   logic                dmg_hit, heal_hit, found_d;
   logic [IDX_W-1:0]    cand_d;
   logic [HP_W:0]       dmg_sum, heal_sum;
   logic [HP_W-1:0]     dmg_acc_d, heal_acc_d, eff_dmg_d, hp_new_d;
   logic signed [SW-1:0] hp_sum_d;

   // Classify the current channel and form saturating accumulator updates
   always_comb begin
      dmg_hit    = bvalid_q[idx_q] && overlap && is_damaging(snap_bc[idx_q], moving_q);
      heal_hit   = bvalid_q[idx_q] && overlap && is_healing(snap_bc[idx_q]);
      dmg_sum    = {1'b0, dmg_acc_q} + (HP_W+1)'(DMG_HIT);
      heal_sum   = {1'b0, heal_acc_q} + (HP_W+1)'(HEAL_AMT);
      dmg_acc_d  = dmg_acc_q;
      heal_acc_d = heal_acc_q;
      found_d    = found_q;
      cand_d     = cand_q;
      if (dmg_hit) begin
         dmg_acc_d = dmg_sum[HP_W] ? '1 : dmg_sum[HP_W-1:0];
         if (!found_q) begin
            found_d = 1'b1;
            cand_d  = idx_q;
         end
      end
      if (heal_hit) begin
         heal_acc_d = heal_sum[HP_W] ? '1 : heal_sum[HP_W-1:0];
      end
   end

   // Net HP for the frame, clamped to [0, HP_MAX]
   always_comb begin
      eff_dmg_d = immune_q ? '0 : dmg_acc_q;
      hp_sum_d  = $signed({2'b00, hp_q}) - $signed({2'b00, eff_dmg_d})
                + $signed({2'b00, heal_acc_q});
      if (hp_sum_d[SW-1]) begin
         hp_new_d = '0;
      end else if (hp_sum_d > $signed(SW'(HP_MAX))) begin
         hp_new_d = HP_W'(HP_MAX);
      end else begin
         hp_new_d = hp_sum_d[HP_W-1:0];
      end
   end

   // Scan FSM: snapshot on tick, one channel per cycle, then apply to HP
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         iframe_q     <= '0;
         immune_q     <= 1'b0;
         hp_q         <= HP_W'(HP_MAX);
         dmg_acc_q    <= '0;
         heal_acc_q   <= '0;
         found_q      <= 1'b0;
         cand_q       <= '0;
         hit_index_q  <= '0;
         hit_pulse_q  <= 1'b0;
         heal_pulse_q <= 1'b0;
         dead_q       <= 1'b0;
         overrun_q    <= 1'b0;
         ppos_q       <= '0;
         psize_q      <= '0;
         moving_q     <= 1'b0;
         bpos_q       <= '0;
         bsize_q      <= '0;
         bcol_q       <= '0;
         bvalid_q     <= '0;
      end else begin
         hit_pulse_q  <= 1'b0;
         heal_pulse_q <= 1'b0;
         if (frame_tick && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (frame_tick && !dead_q) begin
                  ppos_q     <= player_pos;
                  psize_q    <= player_size;
                  moving_q   <= player_moving;
                  bpos_q     <= bullet_pos;
                  bsize_q    <= bullet_size;
                  bcol_q     <= bullet_color;
                  bvalid_q   <= bullet_valid;
                  dmg_acc_q  <= '0;
                  heal_acc_q <= '0;
                  found_q    <= 1'b0;
                  cand_q     <= '0;
                  idx_q      <= '0;
                  immune_q   <= (iframe_q != '0);
                  if (iframe_q != '0) begin
                     iframe_q <= iframe_q - 1'b1;
                  end
                  state_q    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               dmg_acc_q  <= dmg_acc_d;
               heal_acc_q <= heal_acc_d;
               found_q    <= found_d;
               cand_q     <= cand_d;
               if (idx_q == LAST_IDX) begin
                  state_q <= ST_APPLY;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_APPLY: begin
               hp_q         <= hp_new_d;
               hit_pulse_q  <= (hp_new_d < hp_q);
               heal_pulse_q <= (hp_new_d > hp_q);
               if (eff_dmg_d != '0) begin
                  iframe_q    <= IFR_W'(IFRAME_TICKS);
                  hit_index_q <= cand_q;
               end
               if (hp_new_d == '0) begin
                  dead_q <= 1'b1;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign hp_out     = hp_q;
   assign hit_pulse  = hit_pulse_q;
   assign heal_pulse = heal_pulse_q;
   assign hit_index  = hit_index_q;
   assign dead       = dead_q;
   assign busy       = (state_q != ST_IDLE);
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_multi_hit_resolver.sv
// Self-checking bench for multi_hit_resolver: a table of single-bullet
// vectors, hand-written multi-frame sequences, and randomized frames checked
// against an integer-arithmetic model of the frame rules.
module tb_multi_hit_resolver;

   localparam int N      = 8;
   localparam int W      = 8;
   localparam int HP_MAX = 20;
   localparam int DMG    = 4;
   localparam int HEAL   = 2;
   localparam int IFR    = 10;
   localparam int SATV   = 255;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             frame_tick = 1'b0;
   logic [2*W-1:0]   player_pos = '0;
   logic [W-1:0]     player_size = '0;
   logic             player_moving = 1'b0;
   logic [N*2*W-1:0] bullet_pos = '0;
   logic [N*2*W-1:0] bullet_size = '0;
   logic [N*3-1:0]   bullet_color = '0;
   logic [N-1:0]     bullet_valid = '0;
   logic [7:0]       hp_out;
   logic             hit_pulse, heal_pulse, dead, busy, overrun;
   logic [2:0]       hit_index;

   always #5 clk = ~clk;

   multi_hit_resolver dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .player_pos(player_pos), .player_size(player_size), .player_moving(player_moving),
      .bullet_pos(bullet_pos), .bullet_size(bullet_size), .bullet_color(bullet_color),
      .bullet_valid(bullet_valid), .hp_out(hp_out), .hit_pulse(hit_pulse),
      .heal_pulse(heal_pulse), .hit_index(hit_index), .dead(dead), .busy(busy),
      .overrun(overrun)
   );

   int checks = 0;
   int failures = 0;

   // Scene description (plain integers)
   int px, py, ps;
   bit mv;
   int bx [N];
   int by [N];
   int bw [N];
   int bh [N];
   int bc [N];
   bit bv [N];

   // Reference model state
   int m_hp, m_iframe, m_hit_index;
   bit m_dead, m_overrun;
   bit e_hit, e_heal;

   typedef struct {
      string name;
      int    px, py, ps;
      bit    mv;
      int    ch, x, y, w, h, col;
      int    exp_hp;
      bit    exp_hit, exp_heal;
      int    exp_idx;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_scene();
      px = 100; py = 100; ps = 16; mv = 1'b0;
      for (int i = 0; i < N; i++) begin
         bx[i] = 0; by[i] = 0; bw[i] = 0; bh[i] = 0; bc[i] = 0; bv[i] = 1'b0;
      end
   endtask

   task automatic set_bullet(input int ch, input int x, input int y, input int w,
                             input int h, input int col);
      bx[ch] = x; by[ch] = y; bw[ch] = w; bh[ch] = h; bc[ch] = col; bv[ch] = 1'b1;
   endtask

   task automatic drive_inputs();
      player_pos    = {8'(px), 8'(py)};
      player_size   = 8'(ps);
      player_moving = mv;
      for (int i = 0; i < N; i++) begin
         bullet_pos[i*16 +: 16]  = {8'(bx[i]), 8'(by[i])};
         bullet_size[i*16 +: 16] = {8'(bw[i]), 8'(bh[i])};
         bullet_color[i*3 +: 3]  = 3'(bc[i]);
         bullet_valid[i]         = bv[i];
      end
   endtask

   task automatic model_reset();
      m_hp = HP_MAX; m_iframe = 0; m_hit_index = 0; m_dead = 0; m_overrun = 0;
   endtask

   // Evaluate one accepted frame from the scene with integer arithmetic
   task automatic model_frame();
      int dmg, heal, cand, eff, nw;
      bit immune, ovl;
      immune = (m_iframe > 0);
      if (m_iframe > 0) m_iframe--;
      dmg = 0; heal = 0; cand = -1;
      for (int i = 0; i < N; i++) begin
         ovl = bv[i] && bw[i] > 0 && bh[i] > 0 && ps > 0 &&
               px < bx[i] + bw[i] && bx[i] < px + ps &&
               py < by[i] + bh[i] && by[i] < py + ps;
         if (ovl && (bc[i] == 1 || (bc[i] == 2 && mv) || (bc[i] == 3 && !mv))) begin
            dmg = (dmg + DMG > SATV) ? SATV : dmg + DMG;
            if (cand < 0) cand = i;
         end
         if (ovl && bc[i] == 4) heal = (heal + HEAL > SATV) ? SATV : heal + HEAL;
      end
      eff = immune ? 0 : dmg;
      nw  = m_hp - eff + heal;
      if (nw < 0) nw = 0;
      if (nw > HP_MAX) nw = HP_MAX;
      e_hit  = nw < m_hp;
      e_heal = nw > m_hp;
      if (eff > 0) begin
         m_iframe    = IFR;
         m_hit_index = cand;
      end
      if (nw == 0) m_dead = 1;
      m_hp = nw;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      frame_tick = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // Pulse frame_tick for one edge, then wait until the APPLY edge has passed
   task automatic tick_frame(input bit exp_busy, input bit scramble);
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      chk("busy_after_tick", int'(busy), int'(exp_busy));
      if (scramble) begin
         bullet_valid = '0;
         player_pos   = '0;
         player_moving = ~player_moving;
      end
      repeat (N + 1) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string name);
      chk({name, ".hp"}, int'(hp_out), m_hp);
      chk({name, ".hit_pulse"}, int'(hit_pulse), int'(e_hit));
      chk({name, ".heal_pulse"}, int'(heal_pulse), int'(e_heal));
      chk({name, ".hit_index"}, int'(hit_index), m_hit_index);
      chk({name, ".dead"}, int'(dead), int'(m_dead));
      chk({name, ".busy_done"}, int'(busy), 0);
      chk({name, ".overrun"}, int'(overrun), int'(m_overrun));
      $display("frame %s hp=%0d hit=%0d heal=%0d idx=%0d dead=%0d", name, hp_out,
               hit_pulse, heal_pulse, hit_index, dead);
      @(posedge clk);
      #1;
      chk({name, ".hit_clear"}, int'(hit_pulse), 0);
      chk({name, ".heal_clear"}, int'(heal_pulse), 0);
   endtask

   task automatic run_frame(input string name, input bit scramble);
      drive_inputs();
      if (m_dead) begin
         e_hit = 0; e_heal = 0;
         tick_frame(1'b0, 1'b0);
         check_outputs({name, "_dead"});
      end else begin
         model_frame();
         tick_frame(1'b1, scramble);
         check_outputs(name);
      end
   endtask

   task automatic blank_frames(input int n);
      clear_scene();
      for (int i = 0; i < n; i++) run_frame("blank", 1'b0);
   endtask

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{"white_ch3",   100,100,16,0, 3, 105,105,4,4, 1, 16,1,0, 3};
      vecs[1]  = '{"blue_still",  100,100,16,0, 1, 105,105,4,4, 2, 20,0,0, 0};
      vecs[2]  = '{"blue_moving", 100,100,16,1, 1, 105,105,4,4, 2, 16,1,0, 1};
      vecs[3]  = '{"orange_still",100,100,16,0, 6, 105,105,4,4, 3, 16,1,0, 6};
      vecs[4]  = '{"orange_move", 100,100,16,1, 6, 105,105,4,4, 3, 20,0,0, 0};
      vecs[5]  = '{"green_full",  100,100,16,0, 2, 105,105,4,4, 4, 20,0,0, 0};
      vecs[6]  = '{"color5",      100,100,16,0, 2, 105,105,4,4, 5, 20,0,0, 0};
      vecs[7]  = '{"touch_right", 100,100,16,0, 4, 116,105,4,4, 1, 20,0,0, 0};
      vecs[8]  = '{"touch_left",  100,100,16,0, 4,  96,105,4,4, 1, 20,0,0, 0};
      vecs[9]  = '{"zero_width",  100,100,16,0, 5, 105,105,0,4, 1, 20,0,0, 0};
      vecs[10] = '{"edge_nowrap",   0,100,10,0, 7, 250,100,10,10, 1, 20,0,0, 0};
      vecs[11] = '{"edge_hit",    252,100, 2,0, 7, 250,100,10,10, 1, 16,1,0, 7};

      // Reset state
      do_reset();
      chk("rst.hp", int'(hp_out), HP_MAX);
      chk("rst.hit_pulse", int'(hit_pulse), 0);
      chk("rst.heal_pulse", int'(heal_pulse), 0);
      chk("rst.hit_index", int'(hit_index), 0);
      chk("rst.dead", int'(dead), 0);
      chk("rst.busy", int'(busy), 0);
      chk("rst.overrun", int'(overrun), 0);

      // Table-driven single-bullet vectors, each from a fresh reset
      for (int v = 0; v < 12; v++) begin
         do_reset();
         clear_scene();
         px = vecs[v].px; py = vecs[v].py; ps = vecs[v].ps; mv = vecs[v].mv;
         set_bullet(vecs[v].ch, vecs[v].x, vecs[v].y, vecs[v].w, vecs[v].h, vecs[v].col);
         drive_inputs();
         tick_frame(1'b1, 1'b0);
         chk({vecs[v].name, ".hp"}, int'(hp_out), vecs[v].exp_hp);
         chk({vecs[v].name, ".hit_pulse"}, int'(hit_pulse), int'(vecs[v].exp_hit));
         chk({vecs[v].name, ".heal_pulse"}, int'(heal_pulse), int'(vecs[v].exp_heal));
         chk({vecs[v].name, ".hit_index"}, int'(hit_index), vecs[v].exp_idx);
         $display("vector %s hp=%0d hit=%0d idx=%0d", vecs[v].name, hp_out, hit_pulse, hit_index);
      end

      // Invincibility frames: repeated white hits
      do_reset();
      clear_scene();
      set_bullet(2, 105, 105, 4, 4, 1);
      for (int t = 1; t <= 12; t++) run_frame($sformatf("iframe_t%0d", t), 1'b0);
      chk("iframe.final_hp", int'(hp_out), 12);

      // Heal / mixed frames
      do_reset();
      clear_scene();
      set_bullet(0, 105, 105, 4, 4, 1);
      run_frame("mix_hit", 1'b0);
      blank_frames(IFR);
      clear_scene();
      set_bullet(1, 102, 102, 4, 4, 4);
      set_bullet(3, 110, 110, 4, 4, 1);
      run_frame("mix_green_white", 1'b0);
      chk("mix.hp14", int'(hp_out), 14);
      blank_frames(IFR);
      clear_scene();
      set_bullet(5, 102, 102, 4, 4, 4);
      run_frame("mix_green", 1'b0);
      clear_scene();
      set_bullet(0, 102, 102, 4, 4, 4);
      set_bullet(4, 104, 104, 4, 4, 4);
      set_bullet(6, 110, 110, 4, 4, 1);
      run_frame("mix_equal", 1'b0);

      // Death and sticky dead
      do_reset();
      clear_scene();
      for (int i = 0; i < 4; i++) set_bullet(i, 101 + i, 101, 4, 4, 1);
      run_frame("death_4hits", 1'b0);
      blank_frames(IFR);
      clear_scene();
      set_bullet(5, 105, 105, 4, 4, 1);
      run_frame("death_kill", 1'b0);
      chk("death.dead", int'(dead), 1);
      run_frame("death_ignored", 1'b0);
      do_reset();
      chk("death.rst_hp", int'(hp_out), HP_MAX);
      chk("death.rst_dead", int'(dead), 0);

      // Overrun: second tick three cycles into a scan
      do_reset();
      clear_scene();
      set_bullet(3, 105, 105, 4, 4, 1);
      drive_inputs();
      model_frame();
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      m_overrun = 1;
      chk("ovr.flag", int'(overrun), 1);
      repeat (6) @(posedge clk);
      #1;
      check_outputs("overrun_frame");
      repeat (12) @(posedge clk);
      #1;
      chk("ovr.no_second_scan_hp", int'(hp_out), m_hp);
      chk("ovr.sticky", int'(overrun), 1);

      // Reset during scan cycle 4
      do_reset();
      clear_scene();
      set_bullet(0, 105, 105, 4, 4, 1);
      drive_inputs();
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      chk("rstmid.busy", int'(busy), 0);
      chk("rstmid.hp", int'(hp_out), HP_MAX);
      repeat (N + 2) @(posedge clk);
      #1;
      chk("rstmid.hp_later", int'(hp_out), HP_MAX);
      chk("rstmid.hit_pulse", int'(hit_pulse), 0);

      // Inputs changing mid-scan have no effect
      do_reset();
      clear_scene();
      set_bullet(6, 105, 105, 4, 4, 3);
      run_frame("snapshot", 1'b1);

      // Randomized frames against the model
      do_reset();
      for (int f = 0; f < 80; f++) begin
         if (m_dead && $urandom_range(0, 3) == 0) do_reset();
         clear_scene();
         mv = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) begin
            px = $urandom_range(235, 255); py = $urandom_range(235, 255);
         end else begin
            px = $urandom_range(90, 110); py = $urandom_range(90, 110);
         end
         ps = $urandom_range(0, 20);
         if ($urandom_range(0, 2) != 0) begin
            for (int i = 0; i < N; i++) begin
               bv[i] = 1'($urandom_range(0, 1));
               bx[i] = px - 10 + $urandom_range(0, 30);
               by[i] = py - 10 + $urandom_range(0, 30);
               if (bx[i] > 255) bx[i] = 255;
               if (by[i] > 255) by[i] = 255;
               bw[i] = $urandom_range(0, 12);
               bh[i] = $urandom_range(0, 12);
               bc[i] = $urandom_range(0, 7);
            end
         end
         run_frame($sformatf("rand%0d", f), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the bench can never hang
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
